// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
//
// Sequencer and architectural state holder for the multiply/divide unit.
// Lives in the E stage: it accepts mult/multu/div/divu starts from the decoder,
// computes the 64-bit result up front into hold registers, then counts down a
// fixed busy latency before committing the result into HI/LO. It also
// executes mthi/mtlo/mfhi/mflo and generates the D-stage stall request for
// md/mt/mf instructions that would collide with an in-flight operation.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>=1)
//   DIV_CYCLES   busy cycles for div/divu   (>=1)
//
// Optional build macro:
//   MDU_DIV_ZERO_FAST_EN  when defined, div/divu with a zero divisor finishes
//                         after a single busy cycle (HI/LO left unchanged).
//                         When undefined, it takes the full DIV_CYCLES.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   E_MDUOp     operation code: 0 mult, 1 multu, 2 div, 3 divu,
//               4 mtlo, 5 mthi, 6 mflo, 7 mfhi
//   E_MDUStart  E-stage instruction is mult/multu/div/divu
//   E_A         rs operand (forwarded)
//   E_B         rt operand (forwarded)
//   Req         exception/interrupt commit; blocks new E-stage side effects
//   D_MDUUse    D-stage instruction is md, mt or mf
//   busy        operation in flight, or starting this cycle
//   D_MDUStall  stall request for the D stage
//   HI, LO      architectural HI/LO registers
//   E_MDUOut    mfhi/mflo read data (combinational), 0 for other ops
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MDUOp,
    input  logic        E_MDUStart,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        Req,
    input  logic        D_MDUUse,
    output logic        busy,
    output logic        D_MDUStall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_MDUOut
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MFLO  = 3'd6;
    localparam logic [2:0] OP_MFHI  = 3'd7;

    // Counter is at least 4 bits, wider only if a latency parameter needs it.
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        rhi;
    logic [31:0]        rlo;

    // Conditionally negate a magnitude; used to restore signs after the
    // unsigned divide.
    function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
        return neg ? (32'd0 - mag) : mag;
    endfunction

    // -------------------------------------------------------------------------
    // Result datapath (evaluated in the start cycle, captured into rhi/rlo)
    // -------------------------------------------------------------------------
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               a_neg;
    logic               b_neg;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] sq_mag;
    logic        [31:0] sr_mag;
    logic        [31:0] uq;
    logic        [31:0] ur;
    logic               div_zero;
    logic        [31:0] res_hi;
    logic        [31:0] res_lo;
    logic [CNT_W-1:0]   start_cnt;

    assign a_s    = E_A;
    assign b_s    = E_B;
    assign prod_s = 64'(a_s) * 64'(b_s);
    assign prod_u = {32'd0, E_A} * {32'd0, E_B};

    // Signed divide is done on magnitudes so that 0x80000000 / -1 needs no
    // special case: the magnitude quotient is 0x80000000 and the two signs
    // cancel, giving LO=0x80000000, HI=0.
    assign a_neg    = E_A[31];
    assign b_neg    = E_B[31];
    assign a_mag    = apply_sign(E_A, a_neg);
    assign b_mag    = apply_sign(E_B, b_neg);
    assign div_zero = (E_B == 32'd0);
    assign sq_mag   = div_zero ? 32'd0 : (a_mag / b_mag);
    assign sr_mag   = div_zero ? 32'd0 : (a_mag % b_mag);
    assign uq       = div_zero ? 32'd0 : (E_A / E_B);
    assign ur       = div_zero ? 32'd0 : (E_A % E_B);

    always_comb begin
        res_hi    = HI;
        res_lo    = LO;
        start_cnt = CNT_W'(MULT_CYCLES);
        case (E_MDUOp)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                start_cnt = CNT_W'(DIV_CYCLES);
                if (div_zero) begin
                    // Divide by zero commits the current HI/LO back unchanged.
                    res_hi = HI;
                    res_lo = LO;
`ifdef MDU_DIV_ZERO_FAST_EN
                    start_cnt = CNT_W'(1);
`endif
                end else if (E_MDUOp == OP_DIV) begin
                    // Quotient truncates toward zero; remainder follows dividend.
                    res_lo = apply_sign(sq_mag, a_neg ^ b_neg);
                    res_hi = apply_sign(sr_mag, a_neg);
                end else begin
                    res_lo = uq;
                    res_hi = ur;
                end
            end
            default: begin
                res_hi = HI;
                res_lo = LO;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencer: IDLE accepts starts and mt writes; BUSY counts down and
    // commits on the final count. Starts seen while BUSY are ignored, and
    // Req does not abort an operation that is already in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            HI    <= 32'd0;
            LO    <= 32'd0;
            rhi   <= 32'd0;
            rlo   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!Req) begin
                        if (E_MDUStart) begin
                            rhi   <= res_hi;
                            rlo   <= res_lo;
                            cnt   <= start_cnt;
                            state <= BUSY;
                        end else if (E_MDUOp == OP_MTLO) begin
                            LO <= E_A;
                        end else if (E_MDUOp == OP_MTHI) begin
                            HI <= E_A;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        HI    <= rhi;
                        LO    <= rlo;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = E_MDUStart | (state == BUSY);
    assign D_MDUStall = D_MDUUse & busy;

    always_comb begin
        case (E_MDUOp)
            OP_MFLO: E_MDUOut = LO;
            OP_MFHI: E_MDUOut = HI;
            default: E_MDUOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl
//
// Self-checking bench for mdu_ctrl. Directed sequences cover the documented
// scenarios, then a randomized run compares every cycle against a reference
// model that tracks HI/LO and a pending result with its commit time, computing
// results with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef MDU_DIV_ZERO_FAST_EN
    localparam int DIVZ_N = 1;
`else
    localparam int DIVZ_N = DIV_N;
`endif

    logic        clk;
    logic        reset;
    logic [2:0]  E_MDUOp;
    logic        E_MDUStart;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        Req;
    logic        D_MDUUse;
    logic        busy;
    logic        D_MDUStall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] E_MDUOut;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .E_MDUOp   (E_MDUOp),
        .E_MDUStart(E_MDUStart),
        .E_A       (E_A),
        .E_B       (E_B),
        .Req       (Req),
        .D_MDUUse  (D_MDUUse),
        .busy      (busy),
        .D_MDUStall(D_MDUStall),
        .HI        (HI),
        .LO        (LO),
        .E_MDUOut  (E_MDUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model state: architectural HI/LO plus at most one pending
    // result that lands in HI/LO at edge number m_commit.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          m_pend;
    int          m_cyc, m_commit;

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin sp = sa * sb; return sp[63:0]; end
            3'd1: begin up = ua * ub; return up; end
            3'd2: begin
                if (b == 0) return {hi, lo};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 0) return {hi, lo};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // One clock cycle: apply inputs just after a rising edge, check outputs
    // at the falling edge, then advance the model across the next rising edge.
    task automatic cycle(input logic rst, input logic [2:0] op, input logic start,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic req, input logic use_d);
        logic        e_busy;
        logic [31:0] e_out;
        logic [63:0] r;
        int          n;
        reset = rst; E_MDUOp = op; E_MDUStart = start; E_A = a; E_B = b;
        Req = req; D_MDUUse = use_d;
        @(negedge clk);
        e_busy = start | m_pend;
        e_out  = (op == 3'd6) ? m_lo : (op == 3'd7) ? m_hi : 32'd0;
        chk("busy",  {31'd0, busy},       {31'd0, e_busy});
        chk("stall", {31'd0, D_MDUStall}, {31'd0, e_busy & use_d});
        chk("HI",    HI, m_hi);
        chk("LO",    LO, m_lo);
        chk("mdu_out", E_MDUOut, e_out);
        @(posedge clk);
        #1;
        m_cyc++;
        if (rst) begin
            m_hi = 0; m_lo = 0; m_pend = 0;
        end else if (m_pend) begin
            if (m_cyc == m_commit) begin
                m_hi = p_hi; m_lo = p_lo; m_pend = 0;
            end
        end else if (!req) begin
            if (start) begin
                r = ref_result(op, a, b, m_hi, m_lo);
                p_hi = r[63:32]; p_lo = r[31:0];
                n = (op < 3'd2) ? MULT_N : ((b == 0) ? DIVZ_N : DIV_N);
                m_pend = 1; m_commit = m_cyc + n;
            end else if (op == 3'd4) m_lo = a;
            else if (op == 3'd5) m_hi = a;
        end
    endtask

    task automatic idle(input int n, input logic use_d);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd6, 1'b0, 32'd0, 32'd0, 1'b0, use_d);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [5];
        sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFFFFFF;
        sp[3] = 32'h80000000; sp[4] = 32'h7FFFFFFF;
        if ($urandom_range(3) == 0) return sp[$urandom_range(4)];
        if ($urandom_range(3) == 0) return 32'($signed($urandom_range(20)) - 10);
        return $urandom;
    endfunction

    initial begin
        reset = 1; E_MDUOp = 0; E_MDUStart = 0; E_A = 0; E_B = 0; Req = 0; D_MDUUse = 0;
        repeat (2) @(posedge clk);
        #1;
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_pend = 0; m_cyc = 0; m_commit = 0;
        cycle(1'b1, 3'd6, 1'b0, 0, 0, 0, 0);

        // mthi blocked by Req, then accepted, then read back
        cycle(1'b0, 3'd5, 1'b0, 32'h1234, 0, 1'b1, 0);
        chk("mthi_req_blocked", HI, 32'h0);
        cycle(1'b0, 3'd5, 1'b0, 32'h1234, 0, 1'b0, 0);
        chk("mthi_write", HI, 32'h1234);
        cycle(1'b0, 3'd7, 1'b0, 0, 0, 0, 0);
        cycle(1'b0, 3'd4, 1'b0, 32'h55, 0, 0, 0);

        // reset in the middle of a mult discards it
        cycle(1'b0, 3'd0, 1'b1, 32'hFFFFFFFE, 32'd3, 0, 0);
        idle(2, 0);
        cycle(1'b1, 3'd6, 1'b0, 0, 0, 0, 0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        idle(MULT_N + 1, 0);
        chk("rst_no_commit", HI, 32'h0);

        // mult / multu of -2 * 3
        cycle(1'b0, 3'd0, 1'b1, 32'hFFFFFFFE, 32'd3, 0, 0);
        idle(MULT_N, 0);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);
        cycle(1'b0, 3'd1, 1'b1, 32'hFFFFFFFE, 32'd3, 0, 0);
        idle(MULT_N, 0);
        chk("multu_hi", HI, 32'h00000002);
        chk("multu_lo", LO, 32'hFFFFFFFA);

        // div -7 / 2 with a D-stage md/mt/mf waiting the whole time
        cycle(1'b0, 3'd2, 1'b1, 32'hFFFFFFF9, 32'd2, 0, 1'b1);
        idle(DIV_N, 1'b1);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);

        // most-negative / -1
        cycle(1'b0, 3'd2, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        idle(DIV_N, 0);
        chk("divovf_lo", LO, 32'h80000000);
        chk("divovf_hi", HI, 32'h0);

        // divu by zero leaves HI/LO alone
        cycle(1'b0, 3'd5, 1'b0, 32'd5, 0, 0, 0);
        cycle(1'b0, 3'd4, 1'b0, 32'd6, 0, 0, 0);
        cycle(1'b0, 3'd3, 1'b1, 32'd99, 32'd0, 0, 0);
        idle(DIVZ_N, 0);
        chk("divz_hi", HI, 32'd5);
        chk("divz_lo", LO, 32'd6);
        chk("divz_idle", {31'd0, busy}, 32'd0);

        // Req during BUSY does not cancel the commit
        cycle(1'b0, 3'd0, 1'b1, 32'd7, 32'd9, 0, 0);
        idle(1, 0);
        cycle(1'b0, 3'd6, 1'b0, 0, 0, 1'b1, 0);
        idle(MULT_N - 2, 0);
        chk("req_busy_lo", LO, 32'd63);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] op;
            logic       st;
            logic       rs;
            rs = ($urandom_range(99) == 0);
            if (!m_pend && $urandom_range(2) == 0) begin
                op = 3'($urandom_range(3)); st = 1'b1;
            end else begin
                op = 3'($urandom_range(7, 4)); st = 1'b0;
            end
            cycle(rs, op, st, pick(), pick(), ($urandom_range(9) == 0), 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
